// File: rtl/vp_wb_pkg.sv
// Shared constants and types for the vector writeback port scheduler.
// Kind encodings, burst geometry and FSM state encoding.
package vp_wb_pkg;

  localparam int RS_V_SIZE = 4;
  localparam int LANE_SIZE = 8;
  localparam int VLEN      = 32;
  localparam int WB_BEATS  = VLEN / LANE_SIZE;
  localparam int IDX_W     = $clog2(RS_V_SIZE);

  localparam logic [1:0] KIND_LOAD  = 2'b00;
  localparam logic [1:0] KIND_STORE = 2'b01;
  localparam logic [1:0] KIND_ALU   = 2'b10;
  localparam logic [1:0] KIND_RSVD  = 2'b11;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/wb_port_scheduler_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from start, wrapping.
// Purely combinational; no latency, no backpressure.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W:0] pos;

  // Scan from the far end back toward start so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IDX_W+1)'(i);
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Grants completed vector RS entries the shared writeback port, 4 beats x 8 lanes each, round-robin.
// Latency: req at edge N -> wb_valid after N+1; beats advance only on wb_ready, all outputs hold otherwise.
module wb_port_scheduler
  import vp_wb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RS_V_SIZE-1:0]   req,
  input  logic [2*RS_V_SIZE-1:0] req_kind,
  input  logic                   wb_ready,
  output logic                   wb_valid,
  output logic [IDX_W-1:0]       wb_idx,
  output logic [1:0]             wb_kind,
  output logic [1:0]             wb_beat,
  output logic [4:0]             wb_elem_base,
  output logic                   wb_last,
  output logic [RS_V_SIZE-1:0]   rs_clear,
  output logic                   store_done,
  output logic                   busy
);

  localparam logic [1:0]       LAST_BEAT = 2'(WB_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RS_V_SIZE - 1);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W-1:0]       pick_start;
  logic [IDX_W-1:0]       pick_idx;
  logic [RS_V_SIZE-1:0]   done_mask;
  logic [RS_V_SIZE-1:0]   elig;
  logic [RS_V_SIZE-1:0]   cur_oh;
  logic [RS_V_SIZE-1:0]   pick_req;
  logic                   pick_found;
  logic                   last_accept;
  logic                   do_grant;
  logic [1:0]             beat_nxt;

  // One picker serves both the idle grant and the back-to-back re-arbitration.
  always_comb begin
    cur_oh         = '0;
    cur_oh[wb_idx] = 1'b1;
    elig           = req & ~done_mask;
    next_idx       = (wb_idx == LAST_IDX) ? '0 : wb_idx + IDX_W'(1);
    last_accept    = (state == BURST) && wb_ready && wb_last;
    beat_nxt       = wb_beat + 2'd1;
    if (state == BURST) begin
      pick_req   = elig & ~cur_oh;
      pick_start = next_idx;
    end else begin
      pick_req   = elig;
      pick_start = rr_ptr;
    end
    do_grant = pick_found && ((state == IDLE) || last_accept);
  end

  rr_pick #(
    .N     (RS_V_SIZE),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      done_mask    <= '0;
      wb_valid     <= 1'b0;
      wb_idx       <= '0;
      wb_kind      <= '0;
      wb_beat      <= '0;
      wb_elem_base <= '0;
      wb_last      <= 1'b0;
      rs_clear     <= '0;
      store_done   <= 1'b0;
    end else begin
      rs_clear   <= '0;
      store_done <= 1'b0;
      done_mask  <= '0;

      if ((state == BURST) && wb_ready) begin
        if (wb_last) begin
          // done_mask hides the finished entry while its RS req is still falling.
          rs_clear     <= cur_oh;
          store_done   <= (wb_kind == KIND_STORE);
          done_mask    <= cur_oh;
          rr_ptr       <= next_idx;
          state        <= IDLE;
          wb_valid     <= 1'b0;
          wb_beat      <= '0;
          wb_elem_base <= '0;
          wb_last      <= 1'b0;
        end else begin
          wb_beat      <= beat_nxt;
          wb_elem_base <= wb_elem_base + 5'(LANE_SIZE);
          wb_last      <= (beat_nxt == LAST_BEAT);
        end
      end

      // A grant overrides the return to IDLE above, giving bubble-free bursts.
      if (do_grant) begin
        state        <= BURST;
        wb_valid     <= 1'b1;
        wb_idx       <= pick_idx;
        wb_kind      <= req_kind[{pick_idx, 1'b0} +: 2];
        wb_beat      <= '0;
        wb_elem_base <= '0;
        wb_last      <= (LAST_BEAT == 2'd0);
      end
    end
  end

  assign busy = wb_valid;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_wb_port_scheduler;
  import vp_wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] req_kind;
  logic       wb_ready;
  logic       wb_valid;
  logic [1:0] wb_idx;
  logic [1:0] wb_kind;
  logic [1:0] wb_beat;
  logic [4:0] wb_elem_base;
  logic       wb_last;
  logic [3:0] rs_clear;
  logic       store_done;
  logic       busy;

  wb_port_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_kind     (req_kind),
    .wb_ready     (wb_ready),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_kind      (wb_kind),
    .wb_beat      (wb_beat),
    .wb_elem_base (wb_elem_base),
    .wb_last      (wb_last),
    .rs_clear     (rs_clear),
    .store_done   (store_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the visible port state after each clock edge.
  int m_valid = 0, m_idx = 0, m_kind = 0, m_beat = 0;
  int m_clear = 0, m_sd = 0, m_rr = 0, m_excl = 0;

  task automatic model_edge();
    int fin, nclr, nsd, elig, e, got;
    fin = 0; nclr = 0; nsd = 0; got = 0;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_kind = 0; m_beat = 0;
      m_clear = 0; m_sd = 0; m_rr = 0; m_excl = 0;
      return;
    end
    if (m_valid != 0 && wb_ready) begin
      if (m_beat == WB_BEATS - 1) begin
        fin  = 1;
        nclr = 1 << m_idx;
        nsd  = (m_kind == 1) ? 1 : 0;
        m_rr = (m_idx + 1) % 4;
      end else begin
        m_beat = m_beat + 1;
      end
    end
    if (m_valid == 0 || fin != 0) begin
      elig = int'(req) & ~m_excl & ~nclr;
      m_valid = 0;
      m_beat  = 0;
      for (int k = 0; k < 4; k++) begin
        e = (m_rr + k) % 4;
        if (got == 0 && ((elig >> e) & 1) != 0) begin
          got     = 1;
          m_valid = 1;
          m_idx   = e;
          m_kind  = (int'(req_kind) >> (2 * e)) & 3;
        end
      end
    end
    m_clear = nclr;
    m_sd    = nsd;
    m_excl  = nclr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int idx, input int kd,
                           input int beat, input int clr, input int sd);
    chk({tag, ".wb_valid"}, int'(wb_valid), v);
    chk({tag, ".busy"}, int'(busy), v);
    chk({tag, ".wb_beat"}, int'(wb_beat), beat);
    chk({tag, ".wb_elem_base"}, int'(wb_elem_base), beat * LANE_SIZE);
    chk({tag, ".wb_last"}, int'(wb_last), (v != 0 && beat == 3) ? 1 : 0);
    chk({tag, ".rs_clear"}, int'(rs_clear), clr);
    chk({tag, ".store_done"}, int'(store_done), sd);
    if (v != 0) begin
      chk({tag, ".wb_idx"}, int'(wb_idx), idx);
      chk({tag, ".wb_kind"}, int'(wb_kind), kd);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [7:0] kd;
    logic       rdy;
    int         v;
    int         idx;
    int         kind;
    int         beat;
    int         clr;
    int         sd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] rs_req;
    int         rr_order[4];

    rst_n = 1'b0; req = '0; req_kind = '0; wb_ready = 1'b1;

    // rst req kind rdy | valid idx kind beat clear store_done
    tbl.push_back('{1'b0, 4'h0, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h0, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 0, 0, 0});  // single load
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 2, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 3, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{1'b1, 4'h0, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h4, 8'h10, 1'b1, 1, 2, 1, 0, 0, 0});  // store on entry 2
    tbl.push_back('{1'b1, 4'h4, 8'h10, 1'b1, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h4, 8'h10, 1'b0, 1, 2, 1, 1, 0, 0});  // stall at beat 1
    tbl.push_back('{1'b1, 4'h4, 8'h10, 1'b0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h4, 8'h10, 1'b0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h4, 8'h30, 1'b1, 1, 2, 1, 2, 0, 0});  // kind changes mid-burst
    tbl.push_back('{1'b1, 4'h4, 8'h30, 1'b1, 1, 2, 1, 3, 0, 0});
    tbl.push_back('{1'b1, 4'h4, 8'h30, 1'b1, 0, 0, 0, 0, 4, 1});
    tbl.push_back('{1'b1, 4'h0, 8'h30, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h8, 8'hC0, 1'b1, 1, 3, 3, 0, 0, 0});  // reserved kind
    tbl.push_back('{1'b1, 4'h8, 8'hC0, 1'b1, 1, 3, 3, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h8, 8'hC0, 1'b1, 1, 3, 3, 2, 0, 0});
    tbl.push_back('{1'b1, 4'h8, 8'hC0, 1'b1, 1, 3, 3, 3, 0, 0});
    tbl.push_back('{1'b1, 4'h8, 8'hC0, 1'b1, 0, 0, 0, 0, 8, 0});
    tbl.push_back('{1'b1, 4'h0, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 0, 0, 0});  // reset mid-burst
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 2, 0, 0});
    tbl.push_back('{1'b0, 4'h1, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4'h1, 8'h00, 1'b0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 4'h0, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; req = tbl[i].rq; req_kind = tbl[i].kd; wb_ready = tbl[i].rdy;
      step();
      check_out($sformatf("row%0d", i), tbl[i].v, tbl[i].idx, tbl[i].kind,
                tbl[i].beat, tbl[i].clr, tbl[i].sd);
    end

    // Round-robin with req=1011 held: bursts 0,1,3,0 back to back.
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 3; rr_order[3] = 0;
    rst_n = 1'b1; req = 4'b1011; req_kind = 8'h00; wb_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      check_out($sformatf("rr%0d", c), 1, rr_order[c / 4], 0, c % 4,
                (c % 4 == 0 && c > 0) ? (1 << rr_order[c / 4 - 1]) : 0, 0);
    end
    step();
    check_out("rr16", 1, 1, 0, 0, 1, 0);

    // A lone held requester sits out the cycle after its clear.
    rst_n = 1'b0; req = 4'b0000;
    step();
    rst_n = 1'b1; req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c < 4)       check_out($sformatf("excl%0d", c), 1, 0, 0, c, 0, 0);
      else if (c == 4) check_out("excl4", 0, 0, 0, 0, 1, 0);
      else if (c == 5) check_out("excl5", 0, 0, 0, 0, 0, 0);
      else             check_out("excl6", 1, 0, 0, 0, 0, 0);
    end

    // Random traffic: each RS entry holds req until its clear pulse.
    rst_n = 1'b0; req = '0; req_kind = '0; wb_ready = 1'b1;
    step();
    check_out("rand_rst", m_valid, m_idx, m_kind, m_beat, m_clear, m_sd);
    rs_req = '0;
    for (int n = 0; n < 3000; n++) begin
      rs_req = rs_req & ~4'(m_clear);
      for (int i = 0; i < 4; i++) begin
        if (!rs_req[i] && $urandom_range(5) == 0) begin
          rs_req[i] = 1'b1;
          req_kind[2*i +: 2] = 2'($urandom_range(3));
        end
      end
      if (m_valid != 0 && $urandom_range(9) == 0) begin
        req_kind[2*m_idx +: 2] = 2'($urandom_range(3));
      end
      rst_n    = ($urandom_range(399) != 0);
      req      = rs_req;
      wb_ready = ($urandom_range(3) != 0);
      step();
      check_out("rand", m_valid, m_idx, m_kind, m_beat, m_clear, m_sd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Sequences the shared vector writeback port between completed vector reservation-station entries.
- Each vector is 32 elements, written back as 4 beats of 8 lanes.
- Grants one RS entry at a time, round-robin, and issues per-beat element offsets to the ARF/data-memory write datapath.
- Pulses the RS clear for an entry, and store-done for stores, when its last beat is accepted.

Parameters:
- RS_V_SIZE, 4, number of vector RS entries (requesters).
- LANE_SIZE, 8, elements written per beat.
- VLEN, 32, elements per vector register; VLEN/LANE_SIZE = beats per burst (4).
- IDX_W, $clog2(RS_V_SIZE), grant index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  RS_V_SIZE  per entry: busy and execution complete, ready to write back.
- req_kind  in  2*RS_V_SIZE  per-entry kind (00 load, 01 store, 10 alu, 11 reserved); entry i at bits [2i+1:2i].
- wb_ready  in  1  datapath accepts current beat.
- wb_valid  out  1  a beat is presented.
- wb_idx  out  IDX_W  granted RS entry.
- wb_kind  out  2  kind of the granted entry.
- wb_beat  out  2  beat number 0..3.
- wb_elem_base  out  5  wb_beat*LANE_SIZE, the first element of the beat.
- wb_last  out  1  current beat is the final one (beat 3).
- rs_clear  out  RS_V_SIZE  one-hot, one-cycle pulse: clear that RS entry.
- store_done  out  1  one-cycle pulse when a store burst completes.
- busy  out  1  burst in progress (equals wb_valid).

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, rr_ptr 0, beat 0, done_mask 0. Reset mid-burst abandons the burst with no rs_clear and no store_done.
- States: IDLE, BURST.
- Eligibility: elig = req & ~done_mask.
- Round-robin pick: first eligible entry scanning from rr_ptr upward, with wrap-around.
- IDLE:
  - If elig != 0, register the grant (wb_idx, wb_kind latched from req_kind), set beat 0 and go to BURST.
  - Latency: req high at edge N gives wb_valid high after edge N+1.
- BURST:
  - wb_valid = 1.
  - Beat advances only on wb_valid && wb_ready; with wb_ready low, all outputs hold.
  - req and req_kind of the granted entry are ignored during the burst (kind is latched).
  - On acceptance of beat 3 (wb_last && wb_ready), in the next cycle:
    - rs_clear[wb_idx] = 1 for exactly one cycle.
    - store_done = 1 if the latched kind is 01.
    - rr_ptr = wb_idx+1 mod RS_V_SIZE.
    - done_mask = one-hot of the finished entry for one cycle, covering the RS clear latency.
- Back-to-back: on acceptance of beat 3, re-arbitrate in the same cycle.
  - Candidates are elig excluding the current grant, with the pick starting from wb_idx+1.
  - If any candidate exists, go directly to BURST beat 0 for the new entry with no bubble.
  - Otherwise go to IDLE.
- Reserved kind 11: granted and sequenced like alu; never raises store_done.
- wb_elem_base = {wb_beat, 3'b000} for LANE_SIZE 8; wb_beat wraps 3 to 0 only at a burst boundary.
- All outputs are registered; no combinational path from req to wb_valid.

Decomposition:
- Shared package vp_wb_pkg:
  - kind encodings KIND_LOAD, KIND_STORE, KIND_ALU, KIND_RSVD.
  - WB_BEATS = VLEN/LANE_SIZE.
  - state enum {IDLE, BURST}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, start pointer.
  - Outputs: found, index.
  - Instanced once; the back-to-back path feeds it elig with the current grant masked.

Test Plan:
- Single load: req=0001, kind0=00, wb_ready=1.
  - wb_valid high for 4 cycles, wb_idx=0, wb_elem_base 0,8,16,24, wb_last on the 4th.
  - Then rs_clear=0001 for one cycle, store_done=0, return to IDLE.
- Round-robin: req=1011 held from reset.
  - Grant order 0,1,3,0 in contiguous 16-cycle stretch, no idle cycles between bursts.
  - Entry 0 excluded for the cycle after its rs_clear.
- Stall: wb_ready=0 for 3 cycles at beat 1.
  - wb_beat stays 1 and wb_elem_base 8 throughout, outputs stable.
  - Burst completes 3 cycles later than unstalled.
- Store: req=0100, kind2=01.
  - After beat 3 is accepted: rs_clear=0100 and store_done=1 in the same cycle, both for one cycle.
  - A kind-11 entry completes with store_done=0.
- Reset mid-burst: rst_n=0 at beat 2.
  - Next cycle all outputs 0, no rs_clear pulse, rr_ptr=0.
  - After release, re-grant of entry 0 starts at beat 0.
- Kind latch: change req_kind of the granted entry mid-burst.
  - wb_kind unchanged; store_done follows the kind latched at grant.
